// File: rtl/tc_delay_sched_pkg.sv
// Shared types and width helpers for the tc_delay_sched shared delay pipeline.
package tc_delay_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int inflight_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tc_delay_sched_if.sv
// Requester/pipeline-output bundle for tc_delay_sched; master drives requests, slave is the scheduler.
interface tc_delay_sched_if #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int DEPTH     = 2
);
  localparam int TAG_W = tc_delay_sched_pkg::tag_width(NUM_REQ);
  localparam int INF_W = tc_delay_sched_pkg::inflight_width(DEPTH);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*BIT_WIDTH-1:0] in_data;
  logic                         flush;
  logic [NUM_REQ-1:0]           gnt;
  logic                         out_valid;
  logic [BIT_WIDTH-1:0]         out_data;
  logic [TAG_W-1:0]             out_tag;
  logic [INF_W-1:0]             inflight;
  logic                         busy;
  logic                         flush_done;

  modport master (
    output req, in_data, flush,
    input  gnt, out_valid, out_data, out_tag, inflight, busy, flush_done
  );

  modport slave (
    input  req, in_data, flush,
    output gnt, out_valid, out_data, out_tag, inflight, busy, flush_done
  );
endinterface

// File: rtl/tc_delay_sched_arbiter.sv
// One-hot request arbiter: round-robin from a pointer with TC_DELAY_SCHED_FAIR_EN,
// otherwise fixed priority with the lowest index winning.
module tc_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifdef TC_DELAY_SCHED_FAIR_EN
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [PTR_W-1:0]   ptr_nxt_o,
`endif
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);

`ifdef TC_DELAY_SCHED_FAIR_EN
  always_comb begin
    int  idx;
    logic found;
    gnt_o     = '0;
    idx_o     = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o      = PTR_W'(idx);
      end
    end
    if (!found)
      ptr_nxt_o = ptr_i;
    else if (idx_o == PTR_W'(NUM_REQ - 1))
      ptr_nxt_o = '0;
    else
      ptr_nxt_o = idx_o + PTR_W'(1);
  end
`else
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    // Descending scan so the lowest requesting index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = PTR_W'(i);
    end
    if (|req_i) gnt_o[idx_o] = 1'b1;
  end
`endif

endmodule

// File: rtl/tc_delay_sched.sv
// Shared fixed-latency delay pipeline with tagged launch and flush/drain sequencing.
// Build macro TC_DELAY_SCHED_FAIR_EN selects round-robin arbitration (default: fixed priority).
module tc_delay_sched
  import tc_delay_sched_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int DEPTH     = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  tc_delay_sched_if.slave   bus_s
);
  // state    | meaning
  // ST_RUN   | normal operation, one grant per cycle unless flush is sampled
  // ST_DRAIN | grants blocked, bubbles enter stage 0 until the pipeline is empty
  // ST_DONE  | one-cycle flush_done pulse, then back to ST_RUN

  localparam int TAG_W = tag_width(NUM_REQ);
  localparam int INF_W = inflight_width(DEPTH);

  state_e                 state_q;
  logic                   busy_q;
  logic                   done_q;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [TAG_W-1:0]       arb_idx;
  logic                   grant_en;

  logic                   vld_d;
  logic [TAG_W-1:0]       tag_d;
  logic [BIT_WIDTH-1:0]   dat_d;

  logic [DEPTH-1:0]       vld_q;
  logic [TAG_W-1:0]       tag_q [DEPTH];
  logic [BIT_WIDTH-1:0]   dat_q [DEPTH];
  logic [INF_W-1:0]       inflight;

`ifdef TC_DELAY_SCHED_FAIR_EN
  logic [TAG_W-1:0]       ptr_q;
  logic [TAG_W-1:0]       ptr_nxt;
`endif

  tc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (TAG_W)
  ) u_arb (
    .req_i     (bus_s.req),
`ifdef TC_DELAY_SCHED_FAIR_EN
    .ptr_i     (ptr_q),
    .ptr_nxt_o (ptr_nxt),
`endif
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx)
  );

  // Flush beats requests in the cycle it is sampled.
  assign grant_en  = (state_q == ST_RUN) && !bus_s.flush;
  assign bus_s.gnt = grant_en ? arb_gnt : '0;

`ifdef TC_DELAY_SCHED_FAIR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      ptr_q <= '0;
    else if (grant_en && (|arb_gnt))
      ptr_q <= ptr_nxt;
  end
`endif

  always_comb begin
    vld_d = |bus_s.gnt;
    tag_d = vld_d ? arb_idx : '0;
    dat_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus_s.gnt[i]) dat_d = bus_s.in_data[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        tag_q[j] <= '0;
        dat_q[j] <= '0;
      end
    end else begin
      vld_q[0] <= vld_d;
      tag_q[0] <= tag_d;
      dat_q[0] <= dat_d;
      for (int j = 1; j < DEPTH; j++) begin
        vld_q[j] <= vld_q[j-1];
        tag_q[j] <= tag_q[j-1];
        dat_q[j] <= dat_q[j-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int j = 0; j < DEPTH; j++) inflight = inflight + INF_W'(vld_q[j]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          done_q <= 1'b0;
          if (bus_s.flush) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (inflight == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_s.out_valid  = vld_q[DEPTH-1];
  assign bus_s.out_data   = dat_q[DEPTH-1];
  assign bus_s.out_tag    = tag_q[DEPTH-1];
  assign bus_s.inflight   = inflight;
  assign bus_s.busy       = busy_q;
  assign bus_s.flush_done = done_q;

endmodule

// File: tb/tb_tc_delay_sched.sv
// Scoreboard bench for tc_delay_sched: directed plan steps plus randomized traffic vs. a queue-based model.
module tb_tc_delay_sched;
  import tc_delay_sched_pkg::*;

  localparam int BW = 8;
  localparam int NR = 4;
  localparam int DP = 2;
  localparam int TW = tag_width(NR);

  typedef struct {
    logic [TW-1:0] tag;
    logic [BW-1:0] data;
    int            due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tc_delay_sched_if #(.BIT_WIDTH(BW), .NUM_REQ(NR), .DEPTH(DP)) bus ();

  tc_delay_sched #(.BIT_WIDTH(BW), .NUM_REQ(NR), .DEPTH(DP)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_s  (bus)
  );

  exp_t sb[$];
  int   hist[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   m_mode;   // 0 run, 1 drain, 2 done
  int   m_ptr;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [NR-1:0] r);
`ifdef TC_DELAY_SCHED_FAIR_EN
    for (int off = 0; off < NR; off++) begin
      if (r[(m_ptr + off) % NR]) return (m_ptr + off) % NR;
    end
`else
    for (int i = 0; i < NR; i++) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [NR*BW-1:0] rand_data();
    logic [NR*BW-1:0] d;
    for (int i = 0; i < NR; i++) d[i*BW +: BW] = BW'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_ptr  = 0;
    hist.delete();
    repeat (DP) hist.push_back(0);
    sb.delete();
  endtask

  // One clock cycle: apply inputs, check cycle outputs at negedge, advance model at posedge.
  task automatic step(input logic [NR-1:0] r, input logic [NR*BW-1:0] d, input logic f);
    int k;
    int inf;
    logic [NR-1:0] eg;
    bus.req     = r;
    bus.in_data = d;
    bus.flush   = f;
    @(negedge clk);
    k = (m_mode == 0 && !f) ? model_grant(r) : -1;
    eg = '0;
    if (k >= 0) eg[k] = 1'b1;
    inf = 0;
    foreach (hist[i]) inf += hist[i];
    check("gnt", 64'(bus.gnt), 64'(eg));
    check("busy", 64'(bus.busy), 64'(m_mode != 0));
    check("flush_done", 64'(bus.flush_done), 64'(m_mode == 2));
    check("inflight", 64'(bus.inflight), 64'(inf));
    if (k >= 0) sb.push_back('{tag: TW'(k), data: d[k*BW +: BW], due: cyc + DP});
    @(posedge clk);
    case (m_mode)
      0: if (f) m_mode = 1;
      1: if (inf == 0) m_mode = 2;
      default: m_mode = 0;
    endcase
    if (k >= 0) m_ptr = (k + 1) % NR;
    hist.push_front((k >= 0) ? 1 : 0);
    void'(hist.pop_back());
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("out_valid", 64'(bus.out_valid), 64'(1));
        check("out_data", 64'(bus.out_data), 64'(sb[0].data));
        check("out_tag", 64'(bus.out_tag), 64'(sb[0].tag));
        void'(sb.pop_front());
      end else begin
        check("out_valid_idle", 64'(bus.out_valid), 64'(0));
        check("out_data_bubble", 64'(bus.out_data), 64'(0));
        check("out_tag_bubble", 64'(bus.out_tag), 64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR*BW-1:0] d;
    bus.req = '0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_inflight", 64'(bus.inflight), 64'(0));
    check("rst_flush_done", 64'(bus.flush_done), 64'(0));
    rst_n = 1'b1;

    // single request from requester 2
    d = '0;
    d[2*BW +: BW] = 8'hA5;
    step(4'b0100, d, 1'b0);
    idle(4);

    // all requesting continuously
    repeat (6) step(4'b1111, rand_data(), 1'b0);
    idle(DP + 1);

    // flush with a full pipeline and requests still high
    repeat (DP) step(4'b1111, rand_data(), 1'b0);
    step(4'b1111, rand_data(), 1'b1);
    repeat (6) step(4'b1111, rand_data(), 1'b0);
    idle(DP + 1);

    // flush on an empty pipeline
    step('0, '0, 1'b1);
    idle(4);

    // asynchronous reset in the middle of a drain
    repeat (DP) step(4'b1111, rand_data(), 1'b0);
    step(4'b1111, rand_data(), 1'b1);
    step(4'b1111, rand_data(), 1'b0);
    bus.req = '0;
    bus.flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'(0));
    check("arst_out_data", 64'(bus.out_data), 64'(0));
    check("arst_out_tag", 64'(bus.out_tag), 64'(0));
    check("arst_inflight", 64'(bus.inflight), 64'(0));
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_flush_done", 64'(bus.flush_done), 64'(0));
    check("arst_gnt", 64'(bus.gnt), 64'(0));
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b0001, rand_data(), 1'b0);
    idle(DP + 3);

    // randomized traffic with occasional flushes
    for (int n = 0; n < 300; n++) begin
      step(NR'($urandom), rand_data(), ($urandom_range(0, 15) == 0));
    end
    idle(DP + 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tc_delay_sched.md
Name: tc_delay_sched

Overview:
- Shares one fixed-depth delay pipeline (BIT_WIDTH data per stage) between NUM_REQ requesters.
- Arbitrates at most one requester per cycle and launches its word into the pipeline with a source tag.
- Presents each word at the output exactly DEPTH cycles later with valid and tag, so downstream logic can route it back to its source.
- Provides a flush/drain sequence used before reconfiguration or level reset.

Parameters:
- BIT_WIDTH, 8, data width per requester and per pipeline stage.
- NUM_REQ, 4, number of requesters (>=1).
- DEPTH, 2, pipeline stages; launch-to-output latency in cycles (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request, level-sensitive.
- in_data  in  NUM_REQ*BIT_WIDTH  requester i data at bits [i*BIT_WIDTH +: BIT_WIDTH].
- flush  in  1  drain request, sampled on posedge.
- gnt  out  NUM_REQ  one-hot or zero grant, combinational from req, pointer and state.
- out_valid  out  1  pipeline output valid.
- out_data  out  BIT_WIDTH  pipeline output data.
- out_tag  out  TAG_W  requester index of out_data. TAG_W = max(1, clog2(NUM_REQ)).
- inflight  out  clog2(DEPTH+1)  count of valid stages.
- busy  out  1  high when state != RUN.
- flush_done  out  1  single-cycle pulse when drain completes.

Behaviour:
- Reset (rst=0, async):
  - all stage valid/data/tag cleared to 0; RR pointer = 0; state = RUN.
  - out_valid=0, out_data=0, out_tag=0, inflight=0, busy=0, flush_done=0.
- States: RUN, DRAIN, DONE.
  - RUN: if flush=1, go to DRAIN. Otherwise grant. gnt=0 in the cycle flush is sampled high (flush beats req).
  - DRAIN: gnt=0 always; bubbles enter stage 0. When inflight==0 at posedge, go to DONE.
  - DONE: flush_done=1 for exactly one cycle; gnt=0; next state RUN regardless of flush. A flush still high is re-sampled in RUN.
  - Flush with an empty pipeline: RUN->DRAIN->DONE, so flush_done is high 2 cycles after flush is sampled.
- Arbitration (RUN, no flush):
  - Round-robin. Grant the first i with req[i]=1, searching from the RR pointer upward with wrap.
  - On a grant to k, the pointer becomes (k+1) mod NUM_REQ. With no grant, the pointer holds.
  - Requester k is served when gnt[k]=1 at a posedge. No further handshake; requester holds req until served.
- Pipeline:
  - Stage 0 captures {valid = any grant, tag = k, data = in_data[k]}. Stage j captures stage j-1.
  - out_* is registered from the last stage.
  - A word granted in cycle t is on out_* during cycle t+DEPTH.
  - Bubbles (valid=0) carry data=0 and tag=0.
- inflight = popcount of stage valids. Updated each posedge; never exceeds DEPTH.
- Reset mid-drain: returns to RUN with an empty pipeline; no flush_done pulse.

Optional Feature:
- Macro TC_DELAY_SCHED_FAIR_EN.
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority (lowest index wins); pointer logic omitted; all other behaviour unchanged.

Decomposition:
- Shared package tc_delay_sched_pkg holds:
  - state enum {RUN, DRAIN, DONE} (2-bit encoding 0,1,2);
  - TAG_W and inflight-width helper functions.
- One natural sub-module: tc_rr_arbiter (req, pointer -> one-hot gnt, next pointer). It is fixed-priority when TC_DELAY_SCHED_FAIR_EN is undefined.

Test Plan:
- Reset then single request: NUM_REQ=4, DEPTH=2; req=0100, in_data[2]=8'hA5 at cycle 0 -> gnt=0100 in cycle 0; out_valid=1, out_data=A5, out_tag=2 in cycle 2; inflight=1 in cycles 1-2.
- All requesting continuously, FAIR_EN defined -> grants 0001,0010,0100,1000,0001; outputs follow 2 cycles later with tags 0,1,2,3,0.
- Same stimulus, FAIR_EN undefined -> gnt=0001 every cycle; out_tag=0 always.
- Pipeline full (2 words in flight), flush=1 with req=1111 -> gnt=0 from the flush cycle; out_valid for 2 more cycles; flush_done pulse 3 cycles after flush; busy high until then; RUN afterwards with grants resuming.
- Flush on empty pipeline -> flush_done high exactly 2 cycles later, width 1 cycle.
- rst driven low asynchronously mid-DRAIN -> all outputs 0 immediately (before the next edge); no flush_done; after release, req=0001 is granted in the first cycle.
